// File: rtl/gpu_text_writer.sv
// Text-mode bus master for the GPU: writes one character word per cell at the text cursor,
// and runs the control-register copy/blank handshake with polling and timeout.
module gpu_text_writer #(
    parameter logic [7:0]  GPU_ADDR      = 8'h02,
    parameter logic [10:0] CTRL_OFFSET   = 11'd0,
    parameter logic [10:0] CHAR_BASE     = 11'd4,
    parameter int unsigned COLS          = 40,
    parameter int unsigned ROWS          = 30,
    parameter int unsigned POLL_INTERVAL = 16,
    parameter int unsigned POLL_LIMIT    = 65535
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic [7:0]  charIn,
    input  logic [7:0]  attrIn,
    input  logic        charValid,
    output logic        charReady,
    input  logic        presentReq,
    input  logic        clearReq,
    input  logic        modeIn,
    input  logic [11:0] colorIn,
    output logic        presentDone,
    output logic        timeout,
    output logic [63:0] address,
    output logic [63:0] dataOut,
    input  logic [63:0] dataIn,
    output logic        write,
    output logic        read
);

    localparam int unsigned ColW  = $clog2(COLS);
    localparam int unsigned RowW  = $clog2(ROWS);
    localparam int unsigned WaitW = $clog2(POLL_INTERVAL + 1);
    localparam int unsigned PollW = $clog2(POLL_LIMIT + 1);
    localparam logic [63:0] CtrlAddr = {GPU_ADDR, 45'b0, CTRL_OFFSET};

    typedef enum logic [2:0] {StIdle, StWchar, StCwrite, StPwait, StPread, StDone} stateT;

    stateT            state;
    logic [RowW-1:0]  row;
    logic [ColW-1:0]  col;
    logic [WaitW-1:0] waitCnt;
    logic [PollW-1:0] pollCnt;
    logic             opClear;

    logic [10:0]     charOffset;
    logic [RowW-1:0] incRow;
    logic            lastCol;
    logic            accept;
    logic            printable;
    logic            unusedDataIn;

    assign charReady    = (state == StIdle) & ~presentReq & ~clearReq & resetN;
    assign accept       = charValid & charReady;
    assign printable    = (charIn >= 8'h20) && (charIn <= 8'h7E);
    assign unusedDataIn = ^dataIn[63:2];

    always_comb begin
        charOffset = CHAR_BASE + 11'(row) * 11'(COLS) + 11'(col);
        lastCol    = (col == ColW'(COLS - 1));
        incRow     = (row == RowW'(ROWS - 1)) ? '0 : row + RowW'(1);
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state       <= StIdle;
            row         <= '0;
            col         <= '0;
            waitCnt     <= '0;
            pollCnt     <= '0;
            opClear     <= 1'b0;
            timeout     <= 1'b0;
            presentDone <= 1'b0;
            write       <= 1'b0;
            read        <= 1'b0;
            address     <= '0;
            dataOut     <= '0;
        end else begin
            // Strobes and bus values are single-cycle; each state re-asserts what it needs.
            write       <= 1'b0;
            read        <= 1'b0;
            presentDone <= 1'b0;
            address     <= '0;
            dataOut     <= '0;
            unique case (state)
                StIdle: begin
                    if (clearReq || presentReq) begin
                        opClear <= clearReq;
                        pollCnt <= '0;
                        write   <= 1'b1;
                        address <= CtrlAddr;
                        dataOut <= {49'b0, colorIn, modeIn, clearReq ? 2'b10 : 2'b01};
                        state   <= StCwrite;
                    end else if (accept) begin
                        if (printable) begin
                            write   <= 1'b1;
                            address <= {GPU_ADDR, 45'b0, charOffset};
                            dataOut <= {48'b0, attrIn, charIn};
                            state   <= StWchar;
                        end else if (charIn == 8'h0A) begin
                            col <= '0;
                            row <= incRow;
                        end else if (charIn == 8'h0D) begin
                            col <= '0;
                        end
                    end
                end
                StWchar: begin
                    if (lastCol) begin
                        col <= '0;
                        row <= incRow;
                    end else begin
                        col <= col + ColW'(1);
                    end
                    state <= StIdle;
                end
                StCwrite: begin
                    waitCnt <= '0;
                    state   <= StPwait;
                end
                StPwait: begin
                    if (waitCnt == WaitW'(POLL_INTERVAL - 1)) begin
                        read    <= 1'b1;
                        address <= CtrlAddr;
                        state   <= StPread;
                    end else begin
                        waitCnt <= waitCnt + WaitW'(1);
                    end
                end
                StPread: begin
                    if (dataIn[1:0] == 2'b00) begin
                        presentDone <= 1'b1;
                        state       <= StDone;
                    end else if (pollCnt == PollW'(POLL_LIMIT)) begin
                        timeout     <= 1'b1;
                        presentDone <= 1'b1;
                        state       <= StDone;
                    end else begin
                        pollCnt <= pollCnt + PollW'(1);
                        waitCnt <= '0;
                        state   <= StPwait;
                    end
                end
                StDone: begin
                    if (opClear) begin
                        row <= '0;
                        col <= '0;
                    end
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_text_writer.sv
// Scoreboard bench for gpu_text_writer: a cursor/bus reference model queues expected bus events,
// and a monitor pops and compares them whenever the DUT strobes.
module tb_gpu_text_writer;

    localparam int Cols = 40;
    localparam int Rows = 30;
    localparam int PollInterval = 16;
    localparam int PollLimit = 5;
    localparam logic [63:0] CtrlAddr = 64'h0200_0000_0000_0000;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic [7:0]  charIn = '0;
    logic [7:0]  attrIn = '0;
    logic        charValid = 1'b0;
    logic        charReady;
    logic        presentReq = 1'b0;
    logic        clearReq = 1'b0;
    logic        modeIn = 1'b0;
    logic [11:0] colorIn = '0;
    logic        presentDone;
    logic        timeout;
    logic [63:0] address;
    logic [63:0] dataOut;
    logic [63:0] dataIn;
    logic        write;
    logic        read;

    always #5 clock = ~clock;

    gpu_text_writer #(.POLL_LIMIT(PollLimit)) dut (
        .clock(clock), .resetN(resetN), .charIn(charIn), .attrIn(attrIn),
        .charValid(charValid), .charReady(charReady), .presentReq(presentReq),
        .clearReq(clearReq), .modeIn(modeIn), .colorIn(colorIn), .presentDone(presentDone),
        .timeout(timeout), .address(address), .dataOut(dataOut), .dataIn(dataIn),
        .write(write), .read(read)
    );

    typedef struct {
        int          kind;   // 0 write, 1 read, 2 done pulse
        logic [63:0] addr;
        logic [63:0] data;
        int          gap;    // cycles since previous event, -1 = unchecked
    } txnT;

    txnT expQ[$];
    int  compared = 0;
    int  mismatched = 0;
    int  cycle = 0;
    int  readsSeen = 0;
    int  readBase = 0;
    int  busyTarget = 0;
    int  lastStrobe = 0;
    int  mRow = 0;
    int  mCol = 0;
    bit  expTimeout = 1'b0;

    always @(posedge clock) cycle <= cycle + 1;
    always @(posedge clock) if (read) readsSeen <= readsSeen + 1;

    // GPU model: control bits stay busy for the first busyTarget reads of an operation.
    assign dataIn = (read && (readsSeen - readBase) < busyTarget) ? 64'h3 : 64'h0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cycle);
        end
    endfunction

    function automatic void pushTxn(int kind, logic [63:0] addr, logic [63:0] data, int gap);
        txnT t;
        t.kind = kind;
        t.addr = addr;
        t.data = data;
        t.gap  = gap;
        expQ.push_back(t);
    endfunction

    function automatic void modelChar(logic [7:0] c, logic [7:0] a);
        if (c >= 8'h20 && c <= 8'h7E) begin
            pushTxn(0, CtrlAddr | 64'(4 + mRow * Cols + mCol), {48'b0, a, c}, -1);
            mCol++;
            if (mCol == Cols) begin
                mCol = 0;
                mRow = (mRow + 1) % Rows;
            end
        end else if (c == 8'h0A) begin
            mCol = 0;
            mRow = (mRow + 1) % Rows;
        end else if (c == 8'h0D) begin
            mCol = 0;
        end
    endfunction

    always @(negedge clock) begin
        if (resetN) begin
            txnT t;
            int  kind;
            check("exclusive strobes", {62'b0, write, read}, {62'b0, write & ~read, read & ~write});
            if (!write && !read) begin
                check("idle address", address, 64'h0);
                check("idle dataOut", dataOut, 64'h0);
            end
            if (write || read || presentDone) begin
                kind = write ? 0 : (read ? 1 : 2);
                if (expQ.size() == 0) begin
                    check("unexpected strobe", 64'(kind), 64'hFF);
                end else begin
                    t = expQ.pop_front();
                    check("strobe kind", 64'(kind), 64'(t.kind));
                    check("strobe address", address, t.addr);
                    check("strobe data", dataOut, t.data);
                    if (t.gap >= 0) check("strobe gap", 64'(cycle - lastStrobe), 64'(t.gap));
                end
                lastStrobe = cycle;
            end
        end
    end

    task automatic sendChar(input logic [7:0] c, input logic [7:0] a);
        int n = 0;
        @(negedge clock);
        while (!charReady && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!charReady) begin
            check("charReady wait", {63'b0, charReady}, 64'h1);
            return;
        end
        modelChar(c, a);
        charIn = c;
        attrIn = a;
        charValid = 1'b1;
        @(posedge clock);
        #1 charValid = 1'b0;
    endtask

    task automatic doOp(input bit clr, input bit pres, input int busy, input logic [11:0] color,
                        input bit mode, input bit pokeChar);
        int n = 0;
        int nReads;
        @(negedge clock);
        nReads = ((busy < PollLimit) ? busy : PollLimit) + 1;
        pushTxn(0, CtrlAddr, {49'b0, color, mode, clr ? 2'b10 : 2'b01}, -1);
        for (int i = 0; i < nReads; i++) pushTxn(1, CtrlAddr, 64'h0, PollInterval + 1);
        pushTxn(2, 64'h0, 64'h0, 1);
        if (busy > PollLimit) expTimeout = 1'b1;
        readBase = readsSeen;
        busyTarget = busy;
        colorIn = color;
        modeIn = mode;
        clearReq = clr;
        presentReq = pres;
        if (pokeChar) begin
            charIn = 8'h42;
            attrIn = 8'h11;
            charValid = 1'b1;
        end
        @(negedge clock);
        check("charReady during op", {63'b0, charReady}, 64'h0);
        while (!presentDone && n < 5000) begin
            @(negedge clock);
            n++;
        end
        check("presentDone seen", {63'b0, presentDone}, 64'h1);
        clearReq = 1'b0;
        presentReq = 1'b0;
        charValid = 1'b0;
        if (clr) begin
            mRow = 0;
            mCol = 0;
        end
        @(negedge clock);
        check("presentDone single cycle", {63'b0, presentDone}, 64'h0);
        check("timeout flag", {63'b0, timeout}, {63'b0, expTimeout});
    endtask

    task automatic randomChars(input int count);
        logic [7:0] c;
        int r;
        for (int i = 0; i < count; i++) begin
            r = $urandom_range(0, 99);
            if (r < 75)      c = 8'($urandom_range(8'h20, 8'h7E));
            else if (r < 85) c = 8'h0A;
            else if (r < 92) c = 8'h0D;
            else if (r < 96) c = 8'($urandom_range(8'h00, 8'h09));
            else             c = 8'($urandom_range(8'h7F, 8'hFF));
            sendChar(c, 8'($urandom));
        end
    endtask

    initial begin
        // Reset held three cycles: everything quiet.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("reset strobes", {60'b0, write, read, presentDone, charReady}, 64'h0);
            check("reset address", address, 64'h0);
            check("reset dataOut", dataOut, 64'h0);
            check("reset timeout", {63'b0, timeout}, 64'h0);
        end
        resetN = 1'b1;
        @(negedge clock);
        check("charReady after reset", {63'b0, charReady}, 64'h1);

        // First char at home, then fill past the end of row 0.
        sendChar(8'h41, 8'h07);
        for (int i = 1; i < 41; i++) sendChar(8'(8'h41 + i % 26), 8'h07);
        // Walk to (29,39) and write the last cell, then confirm wrap to (0,0).
        sendChar(8'h0D, 8'h00);
        for (int i = 0; i < 28; i++) sendChar(8'h0A, 8'h00);
        for (int i = 0; i < 39; i++) sendChar(8'h2E, 8'h01);
        sendChar(8'h5A, 8'h0F);
        sendChar(8'h21, 8'h02);

        // Newline from (0,5), a dropped control code, then a printable char at (1,0).
        doOp(1'b1, 1'b0, 0, 12'h000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) sendChar(8'h30, 8'h03);
        sendChar(8'h0A, 8'h00);
        sendChar(8'h01, 8'h00);
        @(negedge clock);
        check("charReady after dropped code", {63'b0, charReady}, 64'h1);
        sendChar(8'h58, 8'h04);

        // Present with one busy poll.
        doOp(1'b0, 1'b1, 1, 12'hFFF, 1'b0, 1'b0);
        randomChars(200);

        // Clear and present together; GPU never finishes -> timeout, cursor home.
        doOp(1'b1, 1'b1, 1000, 12'($urandom), 1'b1, 1'b1);
        randomChars(100);
        doOp(1'b0, 1'b1, 0, 12'($urandom), 1'($urandom), 1'b0);
        randomChars(50);

        // Reset during polling aborts with no further strobes and clears timeout.
        @(negedge clock);
        pushTxn(0, CtrlAddr, {49'b0, 12'h123, 1'b1, 2'b01}, -1);
        readBase = readsSeen;
        busyTarget = 100;
        colorIn = 12'h123;
        modeIn = 1'b1;
        presentReq = 1'b1;
        repeat (6) @(negedge clock);
        resetN = 1'b0;
        presentReq = 1'b0;
        @(negedge clock);
        check("mid-op reset strobes", {60'b0, write, read, presentDone, charReady}, 64'h0);
        check("mid-op reset timeout", {63'b0, timeout}, 64'h0);
        @(negedge clock);
        resetN = 1'b1;
        mRow = 0;
        mCol = 0;
        expTimeout = 1'b0;
        repeat (40) @(negedge clock);
        check("no strobes after abort", 64'(expQ.size()), 64'h0);
        randomChars(30);

        repeat (20) @(negedge clock);
        check("scoreboard drained", 64'(expQ.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
